data_mem_controller: RTL and testbench

Data-memory controller for the MEM stage. Converts the MEM stage's load/store request into a registered request/ready handshake on the external data-memory bus. Produces the `MEM_Stall_Controller` signal that the hazard unit ORs into the MEM/EX/ID/IF stall chain. Also owns the big-endian byte-lane steering and the LL/SC reservation.

---
 rtl/data_mem_controller_pkg.sv | 40 ++++
 rtl/mem_lane_align.sv | 62 ++++++
 rtl/data_mem_controller.sv | 185 ++++++++++++++++++
 tb/tb_data_mem_controller.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_controller_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
//   - Controller FSM state type and width.
//   - Byte-enable width for the 32-bit bus.
//   - Access-size decode and alignment helpers.
package data_mem_controller_pkg;

   localparam int unsigned DMC_STATE_WIDTH = 2;
   localparam int unsigned BYTEEN_WIDTH    = 4;

   typedef enum logic [DMC_STATE_WIDTH-1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StDone   = 2'd2
   } dmc_state_e;

   typedef enum logic [1:0] {
      SizeWord = 2'd0,
      SizeHalf = 2'd1,
      SizeByte = 2'd2
   } access_size_e;

   // Byte wins if both size flags are set; neither set means a word.
   function automatic access_size_e decode_size(input logic is_byte, input logic is_half);
      if (is_byte) begin
         return SizeByte;
      end else if (is_half) begin
         return SizeHalf;
      end
      return SizeWord;
   endfunction

   function automatic logic is_misaligned(input access_size_e size, input logic [1:0] addr_lo);
      case (size)
         SizeWord: return addr_lo != 2'b00;
         SizeHalf: return addr_lo[0];
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering for the 32-bit data bus (purely combinational).
// Ports:
//   size       in  : access size (word/half/byte)
//   addr_lo    in  : byte offset within the word
//   sign_ext   in  : sign-extend byte/half loads
//   store_data in  : store data, right-justified
//   load_data  in  : raw word from the bus
//   byte_en    out : lane enables, bit 3 = bits 31:24
//   wr_data    out : store data replicated onto every candidate lane
//   rd_data    out : selected lane, zero/sign extended to 32 bits
module mem_lane_align
   import data_mem_controller_pkg::*;
(
   input  access_size_e            size,
   input  logic [1:0]              addr_lo,
   input  logic                    sign_ext,
   input  logic [31:0]             store_data,
   input  logic [31:0]             load_data,
   output logic [BYTEEN_WIDTH-1:0] byte_en,
   output logic [31:0]             wr_data,
   output logic [31:0]             rd_data
);

   logic [7:0]  lane8;
   logic [15:0] lane16;

   // Offset 0 is the most significant byte.
   always_comb begin
      lane8 = load_data[7:0];
      unique case (addr_lo)
         2'd0: lane8 = load_data[31:24];
         2'd1: lane8 = load_data[23:16];
         2'd2: lane8 = load_data[15:8];
         2'd3: lane8 = load_data[7:0];
      endcase
      lane16 = addr_lo[1] ? load_data[15:0] : load_data[31:16];
   end

   always_comb begin
      byte_en = 4'b1111;
      wr_data = store_data;
      rd_data = load_data;
      case (size)
         SizeByte: begin
            byte_en = 4'b1000 >> addr_lo;
            wr_data = {4{store_data[7:0]}};
            rd_data = {{24{sign_ext & lane8[7]}}, lane8};
         end
         SizeHalf: begin
            byte_en = addr_lo[1] ? 4'b0011 : 4'b1100;
            wr_data = {2{store_data[15:0]}};
            rd_data = {{16{sign_ext & lane16[15]}}, lane16};
         end
         default: begin
            byte_en = 4'b1111;
            wr_data = store_data;
            rd_data = load_data;
         end
      endcase
   end

endmodule

// File: rtl/data_mem_controller.sv
// MEM-stage data-memory controller.
// Turns a load/store in MEM into a registered request/ready access on the data bus,
// stalls the pipeline while the access is outstanding, and tracks the LL/SC reservation.
// Ports:
//   clock, reset_n            : clock, async active-low reset
//   MEM_Mem* / MEM_LLSC       : access type, size, sign, LL/SC marker
//   MEM_Address/MEM_WriteData : byte address, store data
//   IF_Stall                  : pipeline frozen; keeps the FSM parked in DONE
//   Exception_Flush           : drops the LL reservation
//   MEM_ReadData              : load result (1/0 for SC)
//   MEM_Stall_Controller      : hold MEM and earlier stages
//   MEM_AddrErrLoad/Store     : misaligned access flags
//   DataMem_*                 : registered bus request, Ready/ReadData response
module data_mem_controller
   import data_mem_controller_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    MEM_MemRead,
   input  logic                    MEM_MemWrite,
   input  logic                    MEM_MemByte,
   input  logic                    MEM_MemHalf,
   input  logic                    MEM_MemSignExtend,
   input  logic                    MEM_LLSC,
   input  logic [ADDR_WIDTH-1:0]   MEM_Address,
   input  logic [DATA_WIDTH-1:0]   MEM_WriteData,
   input  logic                    IF_Stall,
   input  logic                    Exception_Flush,
   output logic [DATA_WIDTH-1:0]   MEM_ReadData,
   output logic                    MEM_Stall_Controller,
   output logic                    MEM_AddrErrLoad,
   output logic                    MEM_AddrErrStore,
   output logic [ADDR_WIDTH-3:0]   DataMem_Address,
   output logic [DATA_WIDTH-1:0]   DataMem_WriteData,
   output logic [BYTEEN_WIDTH-1:0] DataMem_ByteEn,
   output logic                    DataMem_Read,
   output logic                    DataMem_Write,
   input  logic                    DataMem_Ready,
   input  logic [DATA_WIDTH-1:0]   DataMem_ReadData
);

   dmc_state_e state_q, state_d;

   logic [ADDR_WIDTH-3:0]   addr_q, addr_d;
   logic [BYTEEN_WIDTH-1:0] byte_en_q, byte_en_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    read_q, read_d;
   logic                    write_q, write_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    ll_valid_q, ll_valid_d;
   logic [ADDR_WIDTH-3:0]   ll_addr_q, ll_addr_d;

   access_size_e            size;
   logic [ADDR_WIDTH-3:0]   word_addr;
   logic                    misaligned;
   logic                    is_idle;
   logic                    ll_match;
   logic                    sc_fail;
   logic                    req;
   logic [BYTEEN_WIDTH-1:0] lane_byte_en;
   logic [DATA_WIDTH-1:0]   lane_wr_data;
   logic [DATA_WIDTH-1:0]   lane_rd_data;

   assign size       = decode_size(MEM_MemByte, MEM_MemHalf);
   assign word_addr  = MEM_Address[ADDR_WIDTH-1:2];
   assign misaligned = is_misaligned(size, MEM_Address[1:0]);
   assign is_idle    = (state_q == StIdle);
   assign ll_match   = ll_valid_q & (ll_addr_q == word_addr);

   // Only judged in IDLE: after a successful SC the reservation is already gone in DONE,
   // yet the instruction is still in MEM and must keep seeing its result of 1.
   assign sc_fail = is_idle & MEM_MemWrite & MEM_LLSC & ~ll_match;
   assign req     = (MEM_MemRead | MEM_MemWrite) & ~misaligned & ~sc_fail;

   // MEM inputs are frozen by the stall while in ACCESS, so the live size/offset
   // also select the right lanes when the read data comes back.
   mem_lane_align u_lane_align (
      .size       (size),
      .addr_lo    (MEM_Address[1:0]),
      .sign_ext   (MEM_MemSignExtend),
      .store_data (MEM_WriteData),
      .load_data  (DataMem_ReadData),
      .byte_en    (lane_byte_en),
      .wr_data    (lane_wr_data),
      .rd_data    (lane_rd_data)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      byte_en_d  = byte_en_q;
      wdata_d    = wdata_q;
      read_d     = read_q;
      write_d    = write_q;
      rdata_d    = rdata_q;
      ll_valid_d = ll_valid_q;
      ll_addr_d  = ll_addr_q;

      case (state_q)
         StIdle: begin
            if (req) begin
               state_d   = StAccess;
               addr_d    = word_addr;
               byte_en_d = lane_byte_en;
               wdata_d   = lane_wr_data;
               // A write takes precedence so both strobes can never rise together.
               write_d   = MEM_MemWrite;
               read_d    = MEM_MemRead & ~MEM_MemWrite;
            end
         end
         StAccess: begin
            if (DataMem_Ready) begin
               state_d = StDone;
               read_d  = 1'b0;
               write_d = 1'b0;
               if (read_q) begin
                  rdata_d = lane_rd_data;
                  if (MEM_LLSC) begin
                     ll_valid_d = 1'b1;
                     ll_addr_d  = addr_q;
                  end
               end
               if (write_q) begin
                  // Only a matching SC ever reaches the bus, so it always succeeds here.
                  if (MEM_LLSC) begin
                     rdata_d = 32'd1;
                  end
                  if (ll_valid_q && (addr_q == ll_addr_q)) begin
                     ll_valid_d = 1'b0;
                  end
               end
            end
         end
         StDone: begin
            if (!IF_Stall) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (Exception_Flush) begin
         ll_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         byte_en_q  <= '0;
         wdata_q    <= '0;
         read_q     <= 1'b0;
         write_q    <= 1'b0;
         rdata_q    <= '0;
         ll_valid_q <= 1'b0;
         ll_addr_q  <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         byte_en_q  <= byte_en_d;
         wdata_q    <= wdata_d;
         read_q     <= read_d;
         write_q    <= write_d;
         rdata_q    <= rdata_d;
         ll_valid_q <= ll_valid_d;
         ll_addr_q  <= ll_addr_d;
      end
   end

   assign MEM_Stall_Controller = (is_idle & req) | (state_q == StAccess);
   assign MEM_AddrErrLoad      = MEM_MemRead & misaligned;
   assign MEM_AddrErrStore     = MEM_MemWrite & misaligned;
   assign MEM_ReadData         = sc_fail ? '0 : rdata_q;

   assign DataMem_Address   = addr_q;
   assign DataMem_WriteData = wdata_q;
   assign DataMem_ByteEn    = byte_en_q;
   assign DataMem_Read      = read_q;
   assign DataMem_Write     = write_q;

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench for data_mem_controller with hand-computed expectations.
module tb_data_mem_controller;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        MEM_MemRead, MEM_MemWrite, MEM_MemByte, MEM_MemHalf;
   logic        MEM_MemSignExtend, MEM_LLSC;
   logic [31:0] MEM_Address, MEM_WriteData;
   logic        IF_Stall, Exception_Flush;
   logic [31:0] MEM_ReadData;
   logic        MEM_Stall_Controller, MEM_AddrErrLoad, MEM_AddrErrStore;
   logic [29:0] DataMem_Address;
   logic [31:0] DataMem_WriteData;
   logic [3:0]  DataMem_ByteEn;
   logic        DataMem_Read, DataMem_Write;
   logic        DataMem_Ready;
   logic [31:0] DataMem_ReadData;

   always #5 clock = ~clock;

   data_mem_controller dut (
      .clock                (clock),
      .reset_n              (reset_n),
      .MEM_MemRead          (MEM_MemRead),
      .MEM_MemWrite         (MEM_MemWrite),
      .MEM_MemByte          (MEM_MemByte),
      .MEM_MemHalf          (MEM_MemHalf),
      .MEM_MemSignExtend    (MEM_MemSignExtend),
      .MEM_LLSC             (MEM_LLSC),
      .MEM_Address          (MEM_Address),
      .MEM_WriteData        (MEM_WriteData),
      .IF_Stall             (IF_Stall),
      .Exception_Flush      (Exception_Flush),
      .MEM_ReadData         (MEM_ReadData),
      .MEM_Stall_Controller (MEM_Stall_Controller),
      .MEM_AddrErrLoad      (MEM_AddrErrLoad),
      .MEM_AddrErrStore     (MEM_AddrErrStore),
      .DataMem_Address      (DataMem_Address),
      .DataMem_WriteData    (DataMem_WriteData),
      .DataMem_ByteEn       (DataMem_ByteEn),
      .DataMem_Read         (DataMem_Read),
      .DataMem_Write        (DataMem_Write),
      .DataMem_Ready        (DataMem_Ready),
      .DataMem_ReadData     (DataMem_ReadData)
   );

   int n_vec  = 0;
   int n_miss = 0;

   // Bus request as seen in the first ACCESS cycle, plus stability over the access.
   logic [3:0]  cap_be;
   logic [31:0] cap_wd;
   logic [29:0] cap_addr;
   logic        cap_rd, cap_wr;
   logic        held_ok;
   int          stall_cyc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic set_req(input logic rd, input logic wr, input logic by, input logic hf,
                          input logic sx, input logic ll, input logic [31:0] addr,
                          input logic [31:0] wd);
      MEM_MemRead       = rd;
      MEM_MemWrite      = wr;
      MEM_MemByte       = by;
      MEM_MemHalf       = hf;
      MEM_MemSignExtend = sx;
      MEM_LLSC          = ll;
      MEM_Address       = addr;
      MEM_WriteData     = wd;
   endtask

   task automatic clear_req();
      set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // Return to IDLE from DONE (IF_Stall must be low).
   task automatic go_idle();
      clear_req();
      @(posedge clock);
      #1;
   endtask

   // Called at posedge+1 in IDLE with the request already driven. Ready is raised
   // in ACCESS cycle wait_cyc; returns in the DONE cycle (or at once if no stall).
   task automatic run_access(input int wait_cyc, input logic [31:0] bus_data);
      int cyc;
      stall_cyc = 0;
      held_ok   = 1'b1;
      cap_be    = '0;
      cap_wd    = '0;
      cap_addr  = '0;
      cap_rd    = 1'b0;
      cap_wr    = 1'b0;
      #1;
      if (MEM_Stall_Controller) begin
         stall_cyc = 1;
         for (cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clock);
            #1;
            DataMem_Ready = 1'b0;
            if (!MEM_Stall_Controller) break;
            stall_cyc++;
            if (cyc == 1) begin
               cap_be   = DataMem_ByteEn;
               cap_wd   = DataMem_WriteData;
               cap_addr = DataMem_Address;
               cap_rd   = DataMem_Read;
               cap_wr   = DataMem_Write;
            end else if (DataMem_ByteEn != cap_be || DataMem_WriteData != cap_wd ||
                         DataMem_Address != cap_addr || DataMem_Read != cap_rd ||
                         DataMem_Write != cap_wr) begin
               held_ok = 1'b0;
            end
            if (cyc == wait_cyc) begin
               DataMem_Ready    = 1'b1;
               DataMem_ReadData = bus_data;
            end
         end
         check("done_reached_stall_low", {31'b0, MEM_Stall_Controller}, 32'd0);
         check("done_strobes_low", {30'b0, DataMem_Read, DataMem_Write}, 32'd0);
      end
   endtask

   initial begin
      reset_n          = 1'b0;
      IF_Stall         = 1'b0;
      Exception_Flush  = 1'b0;
      DataMem_Ready    = 1'b0;
      DataMem_ReadData = 32'h0;
      clear_req();
      #1;
      check("rst_read", {31'b0, DataMem_Read}, 32'd0);
      check("rst_write", {31'b0, DataMem_Write}, 32'd0);
      check("rst_byteen", {28'b0, DataMem_ByteEn}, 32'd0);
      check("rst_addr", {2'b0, DataMem_Address}, 32'd0);
      check("rst_rdata", MEM_ReadData, 32'd0);
      check("rst_stall", {31'b0, MEM_Stall_Controller}, 32'd0);
      #20;
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Word load at 0x100, Ready after 2 ACCESS cycles.
      set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
      run_access(2, 32'hDEADBEEF);
      check("wload_stall_cycles", stall_cyc, 32'd3);
      check("wload_byteen", {28'b0, cap_be}, 32'hF);
      check("wload_addr", {2'b0, cap_addr}, 32'h40);
      check("wload_strobes", {30'b0, cap_rd, cap_wr}, 32'd2);
      check("wload_rdata", MEM_ReadData, 32'hDEADBEEF);
      go_idle();

      // Signed byte load at 0x103.
      set_req(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h103, 32'h0);
      run_access(1, 32'h000000F0);
      check("bload_s_byteen", {28'b0, cap_be}, 32'h1);
      check("bload_s_rdata", MEM_ReadData, 32'hFFFFFFF0);
      check("bload_s_stall_cycles", stall_cyc, 32'd2);
      go_idle();

      // Same, unsigned.
      set_req(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h103, 32'h0);
      run_access(1, 32'h000000F0);
      check("bload_u_rdata", MEM_ReadData, 32'h000000F0);
      go_idle();

      // Half store 0xABCD at 0x102, Ready after 3 cycles.
      set_req(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h102, 32'h0000ABCD);
      run_access(3, 32'h0);
      check("hstore_byteen", {28'b0, cap_be}, 32'h3);
      check("hstore_wdata", cap_wd, 32'hABCDABCD);
      check("hstore_strobes", {30'b0, cap_rd, cap_wr}, 32'd1);
      check("hstore_held", {31'b0, held_ok}, 32'd1);
      check("hstore_stall_cycles", stall_cyc, 32'd4);
      check("hstore_rdata_kept", MEM_ReadData, 32'h000000F0);
      go_idle();

      // LL at 0x200, then matching SC.
      set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h0);
      run_access(1, 32'h12345678);
      check("ll_rdata", MEM_ReadData, 32'h12345678);
      go_idle();
      set_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h55);
      run_access(1, 32'h0);
      check("sc_ok_write", {30'b0, cap_rd, cap_wr}, 32'd1);
      check("sc_ok_rdata", MEM_ReadData, 32'd1);
      go_idle();

      // Second SC: reservation gone.
      set_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h66);
      #1;
      check("sc_fail_stall", {31'b0, MEM_Stall_Controller}, 32'd0);
      check("sc_fail_rdata", MEM_ReadData, 32'd0);
      @(posedge clock);
      #1;
      check("sc_fail_no_write", {31'b0, DataMem_Write}, 32'd0);
      go_idle();

      // Misaligned word load and half store.
      set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h101, 32'h0);
      #1;
      check("mis_load_err", {30'b0, MEM_AddrErrLoad, MEM_AddrErrStore}, 32'd2);
      check("mis_load_stall", {31'b0, MEM_Stall_Controller}, 32'd0);
      @(posedge clock);
      #1;
      check("mis_load_no_read", {31'b0, DataMem_Read}, 32'd0);
      set_req(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h101, 32'h0);
      #1;
      check("mis_store_err", {30'b0, MEM_AddrErrLoad, MEM_AddrErrStore}, 32'd1);
      check("mis_store_stall", {31'b0, MEM_Stall_Controller}, 32'd0);
      go_idle();

      // Park in DONE under IF_Stall while Ready keeps toggling in.
      IF_Stall = 1'b1;
      set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104, 32'h0);
      run_access(1, 32'h0BADF00D);
      check("ifs_rdata", MEM_ReadData, 32'h0BADF00D);
      for (int i = 0; i < 2; i++) begin
         DataMem_Ready = 1'b1;
         @(posedge clock);
         #1;
         check("ifs_no_reissue", {30'b0, DataMem_Read, MEM_Stall_Controller}, 32'd0);
         check("ifs_rdata_hold", MEM_ReadData, 32'h0BADF00D);
      end
      DataMem_Ready = 1'b0;
      IF_Stall      = 1'b0;
      go_idle();

      // Exception flush kills a reservation.
      set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 32'h0);
      run_access(1, 32'h11112222);
      go_idle();
      Exception_Flush = 1'b1;
      @(posedge clock);
      #1;
      Exception_Flush = 1'b0;
      set_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 32'h77);
      #1;
      check("flush_sc_stall", {31'b0, MEM_Stall_Controller}, 32'd0);
      check("flush_sc_rdata", MEM_ReadData, 32'd0);
      go_idle();

      // Asynchronous reset in the middle of an access.
      set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h108, 32'h0);
      #1;
      check("rstmid_req_stall", {31'b0, MEM_Stall_Controller}, 32'd1);
      @(posedge clock);
      #1;
      check("rstmid_read_up", {31'b0, DataMem_Read}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("rstmid_strobes", {30'b0, DataMem_Read, DataMem_Write}, 32'd0);
      check("rstmid_addr", {2'b0, DataMem_Address}, 32'd0);
      clear_req();
      #1;
      check("rstmid_idle", {31'b0, MEM_Stall_Controller}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      check("rstmid_no_retry", {31'b0, DataMem_Read}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
